iab_rx: RTL and testbench

//  I-side receiver for the IAB byte link. Sits downstream of the 64->8 IAB

---
 rtl/iab_rx_if.sv | 28 ++
 rtl/iab_rx.sv | 145 ++++++++++++++
 tb/tb_iab_rx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iab_rx_if.sv
// IAB receive-side bundle: serializer link (reqIAB/dataIAB/gntIAB/acceptedI)
// plus the consumer handshake (dataI/validI/takenI), error pulse and frame count.
interface iab_rx_if #(
  parameter int unsigned BYTES = 8,
  parameter int unsigned CNT_W = 16
);
  logic                 reqIAB;
  logic [7:0]           dataIAB;
  logic                 gntIAB;
  logic                 acceptedI;
  logic [8*BYTES-1:0]   dataI;
  logic                 validI;
  logic                 takenI;
  logic                 errI;
  logic [CNT_W-1:0]     frameCnt;

  // Serializer and consumer side
  modport master (
    output reqIAB, dataIAB, takenI,
    input  gntIAB, acceptedI, dataI, validI, errI, frameCnt
  );

  // Receiver side
  modport slave (
    input  reqIAB, dataIAB, takenI,
    output gntIAB, acceptedI, dataI, validI, errI, frameCnt
  );
endinterface

// File: rtl/iab_rx.sv
// I-side IAB receiver: grants the byte link, paces bytes with single-cycle
// acceptedI pulses, reassembles BYTES bytes LSB-first and presents the word
// on a valid/taken handshake. A full frame that finds the output occupied
// parks in STALL until the consumer takes the previous word.
module iab_rx #(
  parameter int unsigned BYTES = 8,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  iab_rx_if.slave  bus
);

  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_PULSE,
    S_GAP,
    S_STALL
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [8*BYTES-1:0] asm_q, asm_d;
  logic [8*BYTES-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic last_byte;
  logic out_free;
  logic gap_done;
  logic abort;

  assign last_byte = (idx_q == IDX_W'(BYTES - 1));
  assign out_free  = !valid_q || bus.takenI;
  assign gap_done  = (gap_q == GAP_W'(GAP - 1));
  // Dropping the request only aborts before the final capture edge.
  assign abort     = !bus.reqIAB &&
                     ((state_q == S_GRANT) || (state_q == S_GAP) ||
                      ((state_q == S_PULSE) && !last_byte));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.reqIAB) state_d = S_GRANT;
      S_GRANT: state_d = abort ? S_IDLE : S_PULSE;
      S_PULSE: begin
        if (abort)           state_d = S_IDLE;
        else if (!last_byte) state_d = S_GAP;
        else if (out_free)   state_d = S_IDLE;
        else                 state_d = S_STALL;
      end
      S_GAP: begin
        if (abort)         state_d = S_IDLE;
        else if (gap_done) state_d = S_PULSE;
      end
      S_STALL: if (bus.takenI) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture, word hand-off, counters and error pulse
  always_comb begin
    idx_d   = idx_q;
    gap_d   = gap_q;
    asm_d   = asm_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    // takenI retires the current word; a load below overrides this.
    valid_d = valid_q && !bus.takenI;
    if (abort) begin
      idx_d = '0;
      gap_d = '0;
      asm_d = '0;
      err_d = 1'b1;
    end else begin
      unique case (state_q)
        S_PULSE: begin
          for (int unsigned b = 0; b < BYTES; b++) begin
            if (idx_q == IDX_W'(b)) asm_d[b*8 +: 8] = bus.dataIAB;
          end
          gap_d = '0;
          if (!last_byte) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            idx_d = '0;
            if (out_free) begin
              data_d  = asm_d;
              valid_d = 1'b1;
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
        end
        S_GAP: gap_d = gap_done ? '0 : gap_q + GAP_W'(1);
        S_STALL: begin
          if (bus.takenI) begin
            data_d  = asm_q;
            valid_d = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.gntIAB    = (state_q == S_GRANT) || (state_q == S_PULSE) || (state_q == S_GAP);
  assign bus.acceptedI = (state_q == S_PULSE);
  assign bus.dataI     = data_q;
  assign bus.validI    = valid_q;
  assign bus.errI      = err_q;
  assign bus.frameCnt  = cnt_q;

endmodule

// File: tb/tb_iab_rx.sv
// Bench for iab_rx: a GAP=1/CNT_W=16 instance and a GAP=3/CNT_W=4 instance,
// driven by a byte-serializer stand-in and checked against a word-level model.
module tb_iab_rx;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       sel   = 1'b0;   // 0: GAP=1 instance, 1: GAP=3 instance
  logic       req_v = 1'b0;
  logic       tk_v  = 1'b0;
  logic [7:0] dat_v = '0;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  iab_rx_if #(.BYTES(8), .CNT_W(16)) bus1 ();
  iab_rx_if #(.BYTES(8), .CNT_W(4))  bus3 ();

  iab_rx #(.BYTES(8), .GAP(1), .CNT_W(16)) u_dut  (.clk(clk), .rst(rst), .bus(bus1));
  iab_rx #(.BYTES(8), .GAP(3), .CNT_W(4))  u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  assign bus1.reqIAB  = req_v && !sel;
  assign bus1.dataIAB = dat_v;
  assign bus1.takenI  = tk_v && !sel;
  assign bus3.reqIAB  = req_v && sel;
  assign bus3.dataIAB = dat_v;
  assign bus3.takenI  = tk_v && sel;

  logic        s_gnt, s_acc, s_valid, s_err;
  logic [63:0] s_data;
  logic [15:0] s_cnt;
  assign s_gnt   = sel ? bus3.gntIAB    : bus1.gntIAB;
  assign s_acc   = sel ? bus3.acceptedI : bus1.acceptedI;
  assign s_valid = sel ? bus3.validI    : bus1.validI;
  assign s_err   = sel ? bus3.errI      : bus1.errI;
  assign s_data  = sel ? bus3.dataI     : bus1.dataI;
  assign s_cnt   = sel ? {12'd0, bus3.frameCnt} : bus1.frameCnt;

  // Word-level model per instance
  logic        m_valid [2];
  logic        m_stall [2];
  logic [63:0] m_data  [2];
  logic [63:0] m_pend  [2];
  logic [15:0] m_cnt   [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (dut%0d): got %h expected %h", tag, sel ? 3 : 1, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_stall[i] = 1'b0;
      m_data[i]  = '0;
      m_pend[i]  = '0;
      m_cnt[i]   = '0;
    end
  endtask

  task automatic check_model(input string pfx);
    int s;
    s = sel ? 1 : 0;
    check({pfx, "_valid"}, 64'(s_valid), 64'(m_valid[s]));
    check({pfx, "_data"},  s_data,       m_data[s]);
    check({pfx, "_cnt"},   64'(s_cnt),   64'(m_cnt[s]));
  endtask

  task automatic model_load(input logic [63:0] word);
    int s;
    s = sel ? 1 : 0;
    m_data[s]  = word;
    m_valid[s] = 1'b1;
    m_cnt[s]   = (m_cnt[s] + 16'd1) & (sel ? 16'h000F : 16'hFFFF);
  endtask

  // Plays the serializer for one frame. stop_after in 1..7 drops the request
  // (or pulses reset when use_rst) after that many bytes were captured.
  task automatic send_frame(input logic [63:0] word, input int stop_after,
                            input bit use_rst, input bit take_last);
    int c, k, captured, g_cycles, gap, s;
    bit prev_acc;
    s   = sel ? 1 : 0;
    gap = sel ? 3 : 1;
    req_v = 1'b1;
    tk_v  = 1'b0;
    dat_v = word[7:0];
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!s_gnt && c < 10);
    check("gnt_rise", 64'(s_gnt), 64'd1);
    if (!s_gnt) begin
      req_v = 1'b0;
      return;
    end
    k = 0; captured = 0; c = 0; g_cycles = 1; prev_acc = 1'b0;
    while (captured < 8 && c < 100) begin
      @(negedge clk);
      c++;
      if (prev_acc) captured++;
      if (s_gnt) g_cycles++;
      if (captured == stop_after) begin
        req_v = 1'b0;
        if (use_rst) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          reset_model();
          check("rst_gnt", 64'(s_gnt), 64'd0);
          check("rst_acc", 64'(s_acc), 64'd0);
          check("rst_err", 64'(s_err), 64'd0);
          check_model("rst");
        end else begin
          @(negedge clk);
          check("abort_gnt", 64'(s_gnt), 64'd0);
          check("abort_acc", 64'(s_acc), 64'd0);
          check("abort_err", 64'(s_err), 64'd1);
          check_model("abort");
          @(negedge clk);
          check("abort_err_end", 64'(s_err), 64'd0);
        end
        return;
      end
      if (s_acc) begin
        check("acc_b2b", 64'(prev_acc & s_acc), 64'd0);
        check("pulse_pos", 64'(c), 64'(1 + k * (gap + 1)));
        dat_v = word[k*8 +: 8];
        k++;
        tk_v = take_last && (k == 8);
      end else begin
        tk_v = 1'b0;
      end
      prev_acc = s_acc;
    end
    req_v = 1'b0;
    tk_v  = 1'b0;
    if (captured < 8) begin
      check("frame_timeout", 64'(captured), 64'd8);
      return;
    end
    check("valid_delay", 64'(c), 64'(1 + 8 + 7 * gap));
    check("gnt_cycles", 64'(g_cycles), 64'(1 + 8 + 7 * gap));
    check("gnt_fall", 64'(s_gnt), 64'd0);
    if (!m_valid[s] || take_last) begin
      model_load(word);
    end else begin
      m_stall[s] = 1'b1;
      m_pend[s]  = word;
    end
    check_model("frame");
  endtask

  task automatic take_word();
    int s;
    s = sel ? 1 : 0;
    tk_v = 1'b1;
    @(negedge clk);
    tk_v = 1'b0;
    if (m_stall[s]) begin
      m_stall[s] = 1'b0;
      model_load(m_pend[s]);
    end else begin
      m_valid[s] = 1'b0;
    end
    check_model("take");
  endtask

  // Keeps requesting while stalled; the grant must stay low.
  task automatic stall_hold(input int n);
    req_v = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("stall_gnt", 64'(s_gnt), 64'd0);
      check_model("stall");
    end
    req_v = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    reset_model();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = (i == 1);
      #1;
      check("reset_gnt", 64'(s_gnt), 64'd0);
      check("reset_acc", 64'(s_acc), 64'd0);
      check("reset_err", 64'(s_err), 64'd0);
      check_model("reset");
    end
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Single frame, then a backpressured frame that must stall
    send_frame(64'h8877665544332211, 99, 1'b0, 1'b0);
    send_frame(64'h0807060504030201, 99, 1'b0, 1'b0);
    check("stall_entered", 64'(m_stall[0]), 64'd1);
    stall_hold(3);
    take_word();

    // Abort after 3 bytes while a word is pending, then a clean frame
    send_frame({$urandom(), $urandom()}, 3, 1'b0, 1'b0);
    take_word();
    send_frame({$urandom(), $urandom()}, 99, 1'b0, 1'b0);

    // Reset after 5 bytes, then recovery
    send_frame({$urandom(), $urandom()}, 5, 1'b1, 1'b0);
    send_frame({$urandom(), $urandom()}, 99, 1'b0, 1'b0);

    // takenI on the last capture edge with validI=1: no stall
    send_frame({$urandom(), $urandom()}, 99, 1'b0, 1'b1);
    check("no_stall", 64'(m_stall[0]), 64'd0);

    // Randomized mix of takes, aborts and back-to-back frames
    for (int i = 0; i < 10; i++) begin
      if (m_valid[0] && $urandom_range(0, 1) == 1) take_word();
      w = {$urandom(), $urandom()};
      send_frame(w, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 99,
                 1'b0, $urandom_range(0, 1) == 1);
      if (m_stall[0]) begin
        stall_hold(int'($urandom_range(1, 3)));
        take_word();
      end
    end

    // GAP=3 instance: spacing, latency and frame counter wrap
    sel = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      send_frame({$urandom(), $urandom()}, 99, 1'b0, 1'b1);
      if (i == 15) check("cnt_wrap", 64'(s_cnt), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
